// File: rtl/ok_ep_pkg.sv
// rtl/ok_ep_pkg.sv - shared host endpoint constants and types
package ok_ep_pkg;

    localparam logic [7:0] PIPE_OUT_BASE = 8'hA0;
    localparam logic [7:0] PIPE_OUT_LAST = 8'hBF;
    localparam int         HOST_DATA_W   = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } blk_state_t;

endpackage

// File: rtl/ok_sync_fifo_fwft.sv
// rtl/ok_sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO core
module ok_sync_fifo_fwft #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_req,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop_req,
    output logic [DATA_W-1:0]     head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  push_ok,
    output logic                  pop_ok
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign pop_ok  = pop_req & ~empty;
    assign push_ok = push_req & (~full | pop_ok);

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates every use.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/ok_pipe_out_fifo.sv
// rtl/ok_pipe_out_fifo.sv - buffered output-pipe endpoint with optional block throttle
module ok_pipe_out_fifo
    import ok_ep_pkg::*;
#(
    parameter logic [7:0] EP_ADDR    = 8'hA0,
    parameter int         DATA_W     = 32,
    parameter int         DEPTH_LOG2 = 9,
    parameter int         BLOCK_MODE = 0,
    parameter int         BLOCK_LEN  = 256
) (
    input  logic                   ti_clk,
    input  logic                   ti_reset,
    input  logic [7:0]             ti_addr,
    input  logic                   ti_read,
    output logic [HOST_DATA_W-1:0] ti_data,
    output logic                   ti_ready,
    output logic                   ep_read,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    level,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   flag_clr
);

    localparam int                  LVL_W = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] BLEN  = LVL_W'(BLOCK_LEN);

    if (BLOCK_LEN < 1 || BLOCK_LEN > (1 << DEPTH_LOG2)) begin : g_bad_block_len
        $error("ok_pipe_out_fifo: BLOCK_LEN must be within 1..2**DEPTH_LOG2");
    end
    if (EP_ADDR < PIPE_OUT_BASE || EP_ADDR > PIPE_OUT_LAST) begin : g_bad_ep_addr
        $error("ok_pipe_out_fifo: EP_ADDR outside the pipe-out address range");
    end

    logic              hit;
    logic [DATA_W-1:0] head;
    logic              push_ok;
    logic              pop_ok;
    blk_state_t        state_q, state_d;
    logic [DEPTH_LOG2:0] bcnt_q, bcnt_d;

    assign hit     = (ti_addr == EP_ADDR);
    assign ep_read = hit & ti_read;
    assign ti_data = (hit & ~empty) ? HOST_DATA_W'(head) : '0;
    assign ti_ready = (BLOCK_MODE != 0) ? (hit & (state_q == ST_BURST)) : hit;

    ok_sync_fifo_fwft #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (ti_clk),
        .rst       (ti_reset),
        .push_req  (wr_en),
        .push_data (wr_data),
        .pop_req   (ep_read),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok)
    );

    // Sticky error flags; a new event wins over a clear in the same cycle.
    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & ~push_ok)  overflow <= 1'b1;
            else if (flag_clr)     overflow <= 1'b0;
            if (ep_read & empty)   underflow <= 1'b1;
            else if (flag_clr)     underflow <= 1'b0;
        end
    end

    // Block throttle state register.
    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Enter a burst only once a whole block is buffered; leave after its last pop.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (level >= BLEN) begin
                    state_d = ST_BURST;
                    bcnt_d  = BLEN;
                end
            end
            ST_BURST: begin
                if (pop_ok) begin
                    bcnt_d = bcnt_q - LVL_W'(1);
                    if (bcnt_q == LVL_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
